// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch sequencer with prefetch FIFO, redirect flush and fault halt

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

module ifu_fetch_ctrl #(
  parameter int INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
  parameter int INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_ADDR_WIDTH-1:0] imem_address,
  output logic                       imem_req,
  input  logic                       imem_ack,
  input  logic [INST_DATA_WIDTH-1:0] imem_data_in,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_DATA_WIDTH-1:0] inst_data,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  output logic                       fetch_halted,
  output logic [INST_ADDR_WIDTH-1:0] fault_pc
);

  localparam int AW = INST_ADDR_WIDTH;
  localparam int DW = INST_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  fetch_pc;
  logic [AW-1:0]  resp_pc;
  logic           inflight;
  logic           discard;
  logic [DW-1:0]  fifo_data [FIFO_DEPTH];
  logic [AW-1:0]  fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [CW:0]    credit_used;
  logic           redirect_act;
  logic           resp_live;
  logic           push, pop, fault;
  logic           unused_redirect_lsbs;

  // redirect_pc[1:0] are architecturally ignored
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A redirect in IDLE only retargets fetch_pc; elsewhere it flushes and drops responses
  assign redirect_act = redirect_valid && (state != IDLE);
  assign resp_live    = inflight && !discard && !redirect_act;
  assign push         = resp_live && imem_ack;
  assign fault        = resp_live && !imem_ack;
  assign pop          = inst_valid && inst_ready && !redirect_act;

  // Credits: FIFO entries plus the outstanding request must never exceed the depth
  assign credit_used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req     = (state == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_address = fetch_pc;

  assign inst_valid   = (count != '0);
  assign inst_data    = fifo_data[rd_ptr];
  assign inst_pc      = fifo_pc[rd_ptr];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: fault halts, redirect overrides everything outside IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fetch_en) state_nx = RUN;
      RUN:     if (!fetch_en) state_nx = IDLE;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
    if (fault)        state_nx = HALT;
    if (redirect_act) state_nx = fetch_en ? RUN : IDLE;
  end

  // Request address and single-outstanding-request tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= BOOT_ADDR;
      resp_pc  <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (redirect_valid)  fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
      else if (imem_req)   fetch_pc <= fetch_pc + AW'(4);
      inflight <= imem_req;
      // A request launched alongside a redirect or a fault must not deliver its word
      discard  <= imem_req && (redirect_act || fault);
      if (imem_req) resp_pc <= fetch_pc;
    end
  end

  // Prefetch FIFO: push acknowledged words, pop on decode handshake, flush on redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_data_in;
        fifo_pc[wr_ptr]   <= resp_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Fault status: latched on a missing acknowledge, cleared by a redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_halted <= 1'b0;
      fault_pc     <= '0;
    end else if (redirect_act) begin
      fetch_halted <= 1'b0;
    end else if (fault) begin
      fetch_halted <= 1'b1;
      fault_pc     <= resp_pc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl

module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_address;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_halted;
  logic [31:0] fault_pc;
  logic [31:0] fail_addr = 32'hFFFF_FFFF;

  int checks = 0;
  int errors = 0;

  ifu_fetch_ctrl #(
    .INST_ADDR_WIDTH(32),
    .INST_DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .BOOT_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_address(imem_address),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .imem_data_in(imem_data_in),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .fetch_halted(fetch_halted),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:         rom = 32'h0010_8093;
      32'h04:         rom = 32'h0480_0113;
      32'h08, 32'h14: rom = 32'h0020_a223;
      default:        rom = 32'hC0DE_0000 | a;
    endcase
  endfunction

  // Registered memory: answers each request on the following cycle
  always @(posedge clk) begin
    imem_ack     <= imem_req && (imem_address != fail_addr);
    imem_data_in <= rom(imem_address);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    fail_addr = 32'hFFFF_FFFF;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic expect_next(input string tag, input logic [31:0] epc, input logic [31:0] edata);
    int n = 0;
    while (!(inst_valid && inst_ready) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    chk({tag, "_pc"}, inst_pc, epc);
    chk({tag, "_data"}, inst_data, edata);
    tick();
  endtask

  initial begin
    int nreq;
    int ndel;
    int post;
    int reqs_after;
    logic [31:0] epc;

    // Reset state
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_halted", {31'b0, fetch_halted}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);

    // Boot stream: one instruction per cycle from cycle 3
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("boot_c1_req", {31'b0, imem_req}, 32'd1);
    chk("boot_c1_addr", imem_address, 32'h0);
    chk("boot_c1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("boot_c2_addr", imem_address, 32'h4);
    chk("boot_c2_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("boot_c3_valid", {31'b0, inst_valid}, 32'd1);
    chk("boot_c3_pc", inst_pc, 32'h0);
    chk("boot_c3_data", inst_data, 32'h0010_8093);
    tick();
    chk("boot_c4_pc", inst_pc, 32'h4);
    chk("boot_c4_data", inst_data, 32'h0480_0113);
    tick();
    chk("boot_c5_pc", inst_pc, 32'h8);
    chk("boot_c5_data", inst_data, 32'h0020_a223);

    // Backpressure: exactly FIFO_DEPTH requests, then in-order release
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    nreq = 0;
    for (int c = 0; c < 22; c++) begin
      tick();
      if (imem_req) begin
        chk("bp_addr", imem_address, 32'(nreq * 4));
        nreq++;
      end
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    chk("bp_req_stalled", {31'b0, imem_req}, 32'd0);
    chk("bp_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_next("bp_rel", 32'(k * 4), rom(32'(k * 4)));

    // Fault: request to 0x5C is not acknowledged
    do_reset();
    fail_addr = 32'h5C;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    epc = 32'h0;
    ndel = 0;
    post = 0;
    reqs_after = 0;
    for (int c = 0; c < 200 && post < 8; c++) begin
      tick();
      if (inst_valid) begin
        chk("flt_pc", inst_pc, epc);
        epc += 32'h4;
        ndel++;
      end
      if (fetch_halted) begin
        post++;
        if (imem_req) reqs_after++;
      end
    end
    chk("flt_ndel", 32'(ndel), 32'd23);
    chk("flt_halted", {31'b0, fetch_halted}, 32'd1);
    chk("flt_fault_pc", fault_pc, 32'h5C);
    chk("flt_reqs_after", 32'(reqs_after), 32'd0);
    chk("flt_drained", {31'b0, inst_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0B;
    fail_addr = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("flt_redir_halted", {31'b0, fetch_halted}, 32'd0);
    chk("flt_redir_req", {31'b0, imem_req}, 32'd1);
    chk("flt_redir_addr", imem_address, 32'h8);
    expect_next("flt_redir", 32'h8, 32'h0020_a223);

    // Redirect coincident with the response for 0x04
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rif_c3_pc", inst_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    chk("rif_c4_valid", {31'b0, inst_valid}, 32'd0);
    chk("rif_c4_req", {31'b0, imem_req}, 32'd1);
    chk("rif_c4_addr", imem_address, 32'h14);
    tick();
    chk("rif_c5_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("rif_c6_valid", {31'b0, inst_valid}, 32'd1);
    chk("rif_c6_pc", inst_pc, 32'h14);
    chk("rif_c6_data", inst_data, 32'h0020_a223);
    tick();
    chk("rif_c7_pc", inst_pc, 32'h18);

    // Redirect together with a pop and a fault response
    do_reset();
    fail_addr = 32'h04;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rpf_c3_valid", {31'b0, inst_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    fail_addr = 32'hFFFF_FFFF;
    chk("rpf_halted", {31'b0, fetch_halted}, 32'd0);
    chk("rpf_fault_pc", fault_pc, 32'h0);
    chk("rpf_valid", {31'b0, inst_valid}, 32'd0);
    chk("rpf_req", {31'b0, imem_req}, 32'd1);
    chk("rpf_addr", imem_address, 32'h40);
    tick();
    tick();
    chk("rpf_c6_pc", inst_pc, 32'h40);
    chk("rpf_c6_data", inst_data, 32'hC0DE_0040);

    // Reset while a request is in flight and three entries are buffered
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("mrst_pre_valid", {31'b0, inst_valid}, 32'd1);
    chk("mrst_pre_req", {31'b0, imem_req}, 32'd0);
    chk("mrst_pre_ack", {31'b0, imem_ack}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    chk("mrst_addr", imem_address, 32'h0);
    inst_ready = 1'b1;
    #1 reset_n = 1'b1;
    tick();
    chk("mrst_ignored", {31'b0, inst_valid}, 32'd0);
    expect_next("mrst_first", 32'h0, 32'h0010_8093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller that sequences the instruction memory (`imemv2`) for the core front end. It generates byte-addressed sequential requests on the imem req/ack port and buffers returned words with their PCs in a small prefetch FIFO. It presents instructions to decode over a valid/ready handshake, handles PC redirects (branch/jump/trap) with flush, and halts fetch when a request returns no acknowledge.

## Interface
- `INST_ADDR_WIDTH`, default `` `CFG_INST_ADDR_WIDTH ``: byte-address width.
- `INST_DATA_WIDTH`, default `` `CFG_INST_DATA_WIDTH ``: instruction width.
- `FIFO_DEPTH`, default 4: prefetch entries; power of 2, ≥2.
- `BOOT_ADDR`, default 0: fetch PC after reset, 4-byte aligned.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `fetch_en`, input, 1: fetch enable.
- `redirect_valid`, input, 1: one-cycle PC redirect pulse.
- `redirect_pc`, input, INST_ADDR_WIDTH: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_address`, output, INST_ADDR_WIDTH: request byte address.
- `imem_req`, output, 1: request strobe.
- `imem_ack`, input, 1: registered response acknowledge, returned the cycle after `imem_req`.
- `imem_data_in`, input, INST_DATA_WIDTH: registered response data.
- `inst_valid`, output, 1: FIFO head valid.
- `inst_ready`, input, 1: decode accepts the head.
- `inst_data`, output, INST_DATA_WIDTH: head instruction.
- `inst_pc`, output, INST_ADDR_WIDTH: head PC.
- `fetch_halted`, output, 1: fetch stopped on a fault.
- `fault_pc`, output, INST_ADDR_WIDTH: address of the faulting request.

## Operation
- **Registers:**
  - `state` ∈ {IDLE, RUN, HALT}.
  - `fetch_pc`: next request address.
  - `inflight`, `resp_pc`, `discard`: tracking for the one outstanding request.
  - FIFO storage, pointers, `count`.
- **Outputs:** `imem_req` = (state==RUN) && (count + inflight < FIFO_DEPTH), a function of registered state only. `imem_address` = `fetch_pc` at all times.
- **On each edge with `imem_req`=1:**
  - `inflight` ← 1, `resp_pc` ← `fetch_pc`, `discard` ← 0.
  - `fetch_pc` ← `fetch_pc` + 4, wrapping modulo 2^INST_ADDR_WIDTH.
- **Response:** every cycle with `inflight`=1 is a response cycle. `inflight` clears unless a new request issues in the same cycle.
  - `discard`=1: response dropped.
  - `imem_ack`=1: push {`imem_data_in`, `resp_pc`} into the FIFO.
  - `imem_ack`=0: fault. No push; state ← HALT; `fetch_halted` ← 1; `fault_pc` ← `resp_pc`.
- **FIFO:**
  - `inst_valid` = (count≠0); `inst_data`/`inst_pc` come from the head entry.
  - Pop occurs when `inst_valid` && `inst_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - The credit rule makes overflow impossible.
- **State transitions:**
  - IDLE→RUN when `fetch_en`=1.
  - RUN→IDLE when `fetch_en`=0. No new requests; the in-flight response is still processed.
  - RUN→HALT on fault. HALT stays until redirect; the FIFO remains drainable.
- **Redirect** (`redirect_valid`=1), highest priority:
  - FIFO flushed (count←0, pointers←0) and pop ignored.
  - `fetch_pc` ← {`redirect_pc`[W-1:2], 2'b00}.
  - Any request issued this cycle, and any response arriving this cycle, is discarded: `discard` ← 1 for the new request, and a simultaneous fault is ignored.
  - HALT→RUN with `fetch_halted` ← 0 if `fetch_en`=1, otherwise →IDLE.
  - In IDLE, only `fetch_pc` is updated.
- **Reset (asynchronous, any time, including mid-request):**
  - state IDLE; `fetch_pc` = BOOT_ADDR; `inflight`, `discard`, `count` = 0.
  - Outputs: `imem_req`=0, `imem_address`=BOOT_ADDR, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fetch_halted`=0, `fault_pc`=0.
  - A memory response in the first cycle after reset release is ignored, because `inflight`=0.

## Timing
- `fetch_en` high in cycle 0 → RUN in cycle 1.
- `imem_req` in cycle 1 → ack in cycle 2 → pushed at the end of cycle 2 → `inst_valid` in cycle 3. Fetch-to-decode latency is 2 cycles from request.
- Steady state: one request per cycle and one instruction per cycle while decode accepts.
- With decode stalled, requests stop once count + inflight = FIFO_DEPTH. They resume in the cycle after a pop frees a credit.
- Redirect in cycle N → first request to the target in cycle N+1 → its instruction is valid in cycle N+3.
- A fault response in cycle N → `fetch_halted`=1 from cycle N+1, with no `imem_req` from cycle N+1.

## Test plan
- **Boot stream:** reset, then `fetch_en`=1, `inst_ready`=1. Instructions arrive as 0x00108093 @pc 0x00, then 0x04800113 @0x04, then 0x0020a223 @0x08. One per cycle from cycle 3, no gaps.
- **Backpressure:** `inst_ready`=0 for 20 cycles with FIFO_DEPTH=4. Exactly 4 requests issue (0x00–0x0C), `imem_req` then stays 0, and no words are lost or duplicated on release.
- **Fault:** run from 0. Words 0x00–0x58 are delivered, the request to 0x5C returns ack=0, then `fetch_halted`=1, `fault_pc`=0x5C, and no further `imem_req`. Redirect to 0x08 gives `fetch_halted`=0 and 0x0020a223 @0x08.
- **Redirect in flight:** redirect to 0x14 in the same cycle as the response for 0x04. The 0x04 word is dropped and the FIFO is emptied. The next delivered entry is 0x0020a223 @0x14, with no stale PCs.
- **Redirect plus pop plus fault:** redirect coincident with a pop and a fault response. No halt occurs, `count`=0, and fetch resumes at the target.
- **Reset mid-operation:** assert `reset_n`=0 while `inflight`=1 and count=3. Immediately `inst_valid`=0 and `imem_req`=0. After release, the first delivered PC is BOOT_ADDR.
